// File: rtl/conway_mode_controller.sv
// Mode sequencer for the Conway system memory: turns host commands into
// exact-length LOAD / RUN / OUTPUT bursts with a one-cycle DONE pulse.
module conway_mode_controller #(
  parameter int data_size = 64,
  parameter int gen_width = 16
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 CMD_LOAD,
  input  logic                 CMD_RUN,
  input  logic                 CMD_OUTPUT,
  input  logic [gen_width-1:0] GEN_COUNT,
  input  logic                 SERIAL_IN_VALID,
  input  logic                 ABORT,
  output logic                 LOAD_MODE,
  output logic                 RUN_MODE,
  output logic                 OUTPUT_MODE,
  output logic                 SERIAL_OUT_VALID,
  output logic                 BUSY,
  output logic                 DONE
);

  localparam int CNT_W = $clog2(data_size) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(data_size - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_OUTPUT,
    S_DRAIN
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [CNT_W-1:0]     w_bit_cnt_nxt;
  logic [gen_width-1:0] r_gen_cnt;
  logic [gen_width-1:0] w_gen_cnt_nxt;
  logic                 r_done;
  logic                 w_done_nxt;
  logic                 r_serial_out_valid;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state            <= S_IDLE;
      r_bit_cnt          <= '0;
      r_gen_cnt          <= '0;
      r_done             <= 1'b0;
      r_serial_out_valid <= 1'b0;
    end else begin
      r_state            <= w_state_nxt;
      r_bit_cnt          <= w_bit_cnt_nxt;
      r_gen_cnt          <= w_gen_cnt_nxt;
      r_done             <= w_done_nxt;
      r_serial_out_valid <= (r_state == S_OUTPUT);
    end
  end

  // r_gen_cnt holds generations still to run, including the current cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_gen_cnt_nxt = r_gen_cnt;
    w_done_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_bit_cnt_nxt = '0;
        if (CMD_RUN) begin
          if (GEN_COUNT == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt   = S_RUN;
            w_gen_cnt_nxt = GEN_COUNT;
          end
        end else if (CMD_LOAD) begin
          w_state_nxt = S_LOAD;
        end else if (CMD_OUTPUT) begin
          w_state_nxt = S_OUTPUT;
        end
      end
      S_LOAD: begin
        if (ABORT) begin
          w_state_nxt   = S_IDLE;
          w_bit_cnt_nxt = '0;
        end else if (SERIAL_IN_VALID) begin
          if (r_bit_cnt == LAST_BIT) begin
            w_state_nxt   = S_IDLE;
            w_bit_cnt_nxt = '0;
            w_done_nxt    = 1'b1;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end
      end
      S_RUN: begin
        if (ABORT) begin
          w_state_nxt   = S_IDLE;
          w_gen_cnt_nxt = '0;
        end else if (r_gen_cnt == gen_width'(1)) begin
          w_state_nxt   = S_IDLE;
          w_gen_cnt_nxt = '0;
          w_done_nxt    = 1'b1;
        end else begin
          w_gen_cnt_nxt = r_gen_cnt - 1'b1;
        end
      end
      S_OUTPUT: begin
        if (r_bit_cnt == LAST_BIT) begin
          w_state_nxt   = S_DRAIN;
          w_bit_cnt_nxt = '0;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        w_state_nxt = S_IDLE;
        w_done_nxt  = 1'b1;
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_bit_cnt_nxt = '0;
        w_gen_cnt_nxt = '0;
      end
    endcase
  end

  assign LOAD_MODE        = (r_state == S_LOAD) && SERIAL_IN_VALID;
  assign RUN_MODE         = (r_state == S_RUN);
  assign OUTPUT_MODE      = (r_state == S_OUTPUT);
  assign SERIAL_OUT_VALID = r_serial_out_valid;
  assign BUSY             = (r_state != S_IDLE);
  assign DONE             = r_done;

endmodule

// File: doc/conway_mode_controller.md
Name: conway_mode_controller

Overview:
- Sequencing FSM driving the LOAD_MODE / RUN_MODE / OUTPUT_MODE controls of the system memory shift register.
- Turns host commands into exact-length mode bursts:
  - load exactly data_size serial bits;
  - run N generations;
  - read out exactly data_size bits, so circular readout never leaves memory rotated.
- Mode outputs are mutually exclusive by construction.

Parameters:
- data_size, 64, grid bits in system memory; also load and readout burst length.
- gen_width, 16, width of the generation count.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- CMD_LOAD  input  1  request serial load; sampled in IDLE only.
- CMD_RUN  input  1  request run; sampled in IDLE only.
- CMD_OUTPUT  input  1  request serial readout; sampled in IDLE only.
- GEN_COUNT  input  gen_width  generations to run; captured when CMD_RUN is accepted.
- SERIAL_IN_VALID  input  1  external serial bit valid this cycle.
- ABORT  input  1  terminate LOAD or RUN early.
- LOAD_MODE  output  1  to memory: shift in SERIAL_IN this edge.
- RUN_MODE  output  1  to memory: capture GRID_IN this edge.
- OUTPUT_MODE  output  1  to memory: rotate and emit MSB this edge.
- SERIAL_OUT_VALID  output  1  memory serial output holds a valid bit this cycle.
- BUSY  output  1  FSM not in IDLE.
- DONE  output  1  one-cycle completion pulse.

Behaviour:
- Reset (RESET_N low, asynchronous):
  - state returns to IDLE;
  - all counters cleared;
  - all outputs 0.
  - Reset mid-operation aborts without DONE. Memory contents are not restored.
- States:
  - IDLE, LOAD, RUN and OUTPUT;
  - DRAIN, one cycle after OUTPUT.
- Command acceptance in IDLE:
  - Priority is RUN > LOAD > OUTPUT; lower-priority simultaneous commands are dropped.
  - Commands are ignored in every other state.
  - A command asserted in the DONE-pulse cycle is accepted, because the FSM is in IDLE.
  - A command accepted at edge k puts the FSM in the new state from edge k.
- LOAD:
  - LOAD_MODE = SERIAL_IN_VALID; it is the only combinational output.
  - The bit counter increments on each valid cycle.
  - The data_size-th accepted bit (counter = data_size-1 with valid) moves the FSM to IDLE. DONE pulses in the following cycle.
  - Gaps in SERIAL_IN_VALID stall the counter indefinitely.
- RUN:
  - GEN_COUNT = 0: no transition, no RUN_MODE; DONE pulses in the next cycle.
  - Otherwise RUN_MODE is high (registered state decode) for exactly GEN_COUNT consecutive cycles. The FSM then returns to IDLE and DONE pulses.
  - Maximum count is 2^gen_width-1; there is no wrap.
- OUTPUT:
  - OUTPUT_MODE is high for exactly data_size consecutive cycles, then one DRAIN cycle, then IDLE.
  - SERIAL_OUT_VALID is OUTPUT_MODE delayed one cycle, since the memory registers SERIAL_OUT. It is high for data_size cycles, the last of which is DRAIN.
  - DONE pulses in the first IDLE cycle after DRAIN.
- ABORT:
  - In LOAD or RUN: the next edge goes to IDLE, mode outputs drop immediately at that edge, and no DONE.
  - ABORT is ignored in OUTPUT and DRAIN. Readout always completes, so the memory ends unrotated.
  - ABORT and a command together in IDLE: the command wins and ABORT has no effect.
- Invariants:
  - At most one of LOAD_MODE, RUN_MODE, OUTPUT_MODE is high in any cycle.
  - BUSY = (state != IDLE).
  - DONE is never high while BUSY.
- Counter width is clog2(data_size)+1 for bits and gen_width for generations.

Test Plan:
- Reset, then CMD_LOAD, then 64 consecutive SERIAL_IN_VALID cycles with pattern 0xA5A5_0000_FFFF_1234 -> 64 LOAD_MODE cycles, BUSY low the cycle after the last bit, DONE one pulse, memory holds the pattern.
- CMD_OUTPUT after that load -> OUTPUT_MODE high for 64 cycles, SERIAL_OUT_VALID high for 64 cycles offset by +1 with bits MSB-first equal to the pattern, DONE after DRAIN. A second CMD_OUTPUT reproduces an identical stream.
- CMD_RUN with GEN_COUNT=5 -> RUN_MODE high exactly 5 cycles, DONE once; CMD_RUN with GEN_COUNT=0 -> zero RUN_MODE cycles, DONE on the next cycle.
- CMD_RUN+CMD_LOAD+CMD_OUTPUT in the same IDLE cycle -> RUN accepted only; CMD_LOAD during RUN ignored; CMD_LOAD in the DONE cycle accepted.
- LOAD with valid toggling every other cycle and ABORT after 10 bits -> 10 LOAD_MODE pulses, IDLE next cycle, no DONE. ABORT during OUTPUT at bit 20 -> all 64 bits still emitted.
- RESET_N pulsed low mid-RUN (GEN_COUNT=100, at cycle 40) -> all outputs 0 asynchronously, IDLE after release, no DONE.
